// File: rtl/mem_access_unit.sv
// MEM-phase responder: runs one load/store against a ready-handshaked RAM with
// fixed read latency and returns a one-cycle done pulse. Optional ISSUE timeout via MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              timeout,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_ready,
  input  logic [31:0]       ram_rdata
);

  // RAM handshake: a beat transfers at a rising edge where ram_en && ram_ready;
  // ram_addr/ram_we/ram_wdata stay constant while ram_en waits for ram_ready.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state, state_next;
  logic          we_q, uns_q;
  logic [1:0]    size_q, off_q;
  logic [LW-1:0] lat_cnt;
  logic          req_ok, accept, lat_done, to_hit, done_entry;
  logic [3:0]    st_we;
  logic [31:0]   st_wdata, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign req_ok = (req_size == 2'b00) ||
                  (req_size == 2'b01 && !req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] == 2'b00);
  assign accept   = (state == S_ISSUE) && ram_ready;
  assign lat_done = (state == S_WAIT) && (lat_cnt == LW'(RD_LAT - 1));

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_q;

  assign to_hit  = (state == S_ISSUE) && !ram_ready && (to_cnt == TW'(TIMEOUT - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE && req) to_cnt <= '0;
      else if (state == S_ISSUE && !ram_ready) to_cnt <= to_cnt + 1'b1;
      if (done_entry) timeout_q <= to_hit;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req) state_next = req_ok ? S_ISSUE : S_DONE;
      S_ISSUE: begin
        if (accept)      state_next = we_q ? S_DONE : S_WAIT;
        else if (to_hit) state_next = S_DONE;
      end
      S_WAIT:  if (lat_done) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign done_entry = (state_next == S_DONE) && (state != S_DONE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign ram_en     = (state == S_ISSUE);

  // Store lane steering from the live request, captured on the req edge.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        st_we    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!req_we) st_we = 4'b0000;
  end

  assign ld_byte = ram_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    ld_data = ram_rdata;
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      ram_addr   <= '0;
      ram_wdata  <= 32'h0;
      ram_we     <= 4'b0000;
      lat_cnt    <= '0;
      rdata      <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      if (state == S_IDLE && req) begin
        we_q      <= req_we;
        uns_q     <= req_unsigned;
        size_q    <= req_size;
        off_q     <= req_addr[1:0];
        ram_addr  <= req_addr[ADDR_W-1:2];
        ram_wdata <= st_wdata;
        ram_we    <= req_ok ? st_we : 4'b0000;
      end
      if (accept)              lat_cnt <= '0;
      else if (state == S_WAIT) lat_cnt <= lat_cnt + 1'b1;
      // Stores, errors and timeouts all report rdata=0.
      if (done_entry) begin
        rdata      <= lat_done ? ld_data : 32'h0;
        misaligned <= (state == S_IDLE);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fake RAM with random stalls, byte-level reference
// memory, cycle-window expectations and directed literal pins.
module tb_mem_access_unit;

  localparam int RD_LAT  = 2;
  localparam int TMO_CYC = 8;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk, reset;
  logic        req, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, misaligned, timeout, ram_en, ram_ready;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;

  mem_access_unit #(.ADDR_W(32), .RD_LAT(RD_LAT), .TIMEOUT(TMO_CYC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned), .timeout(timeout),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ready(ram_ready), .ram_rdata(ram_rdata)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0]  ref_b [int];
  logic [31:0] ram_w [int];
  int          t_n = -10, t_a = -10, t_d = -10;
  bit          t_err, t_store;
  logic [31:0] t_addr, t_we, t_wd, t_rdata;
  logic        t_mis, t_tmo;
  logic [31:0] held_rdata = 0;
  logic        held_mis = 0, held_tmo = 0;
  int          ready_from = 0;
  int          done_seen = 0, last_done_cyc = -1;
  int          last_acc_cyc = -1;
  logic [31:0] last_acc_addr, last_acc_wd;
  logic [3:0]  last_acc_we;

  function automatic logic [7:0] rb(input int a);
    return ref_b.exists(a) ? ref_b[a] : 8'h00;
  endfunction

  task automatic poke_word(input int widx, input logic [31:0] val);
    ram_w[widx] = val;
    for (int k = 0; k < 4; k++) ref_b[4*widx + k] = val[8*k +: 8];
  endtask

  // ---------------- fake RAM ----------------
  initial begin
    logic        acc;
    logic [3:0]  we_s;
    logic [29:0] a_s;
    logic [31:0] wd_s, w, rd;
    logic [31:0] pd [RD_LAT];
    bit          pv [RD_LAT];
    for (int i = 0; i < RD_LAT; i++) begin pd[i] = 0; pv[i] = 0; end
    ram_ready = 1'b0;
    ram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      acc  = ram_en && ram_ready && !reset;
      we_s = ram_we; a_s = ram_addr; wd_s = ram_wdata;
      if (acc) begin
        last_acc_cyc = cyc; last_acc_addr = {2'b00, a_s}; last_acc_we = we_s; last_acc_wd = wd_s;
      end
      @(posedge clk); #1;
      for (int i = RD_LAT - 1; i > 0; i--) begin pd[i] = pd[i-1]; pv[i] = pv[i-1]; end
      pv[0] = 1'b0;
      if (acc) begin
        w = ram_w.exists(int'(a_s)) ? ram_w[int'(a_s)] : 32'h0;
        if (we_s != 4'b0000) begin
          for (int k = 0; k < 4; k++) if (we_s[k]) w[8*k +: 8] = wd_s[8*k +: 8];
          ram_w[int'(a_s)] = w;
        end else begin
          pd[0] = w; pv[0] = 1'b1;
        end
      end
      rd = $urandom();
      ram_rdata = pv[RD_LAT-1] ? pd[RD_LAT-1] : rd;
      ram_ready = (cyc >= ready_from);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int c;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_rdata = 0; held_mis = 0; held_tmo = 0;
      end else begin
        c = cyc;
        check("busy", busy, (c >= t_n + 1 && c <= t_d));
        check("done", done, (c == t_d));
        check("ram_en", ram_en, (!t_err && c >= t_n + 1 && c <= t_a));
        if (!t_err && c >= t_n + 1 && c <= t_a) begin
          check("ram_addr", {2'b00, ram_addr}, t_addr);
          check("ram_we", ram_we, t_we);
          if (t_store) check("ram_wdata", ram_wdata, t_wd);
        end
        if (c == t_d) begin
          held_rdata = t_rdata; held_mis = t_mis; held_tmo = t_tmo;
        end
        check("rdata", rdata, held_rdata);
        check("misaligned", misaligned, held_mis);
        check("timeout", timeout, held_tmo);
        if (done) begin done_seen++; last_done_cyc = c; end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input bit extra, input bit rst_mid);
    int n, nb, pulse, d0;
    bit err, tmo;
    logic [31:0] v, m;
    @(posedge clk); #1;
    n   = cyc;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (addr % nb != 0);
    tmo = !err && TMO_EN && (stall >= TMO_CYC);
    t_err = err; t_store = we; t_n = n;
    t_a = err ? n : (tmo ? n + TMO_CYC : n + 1 + stall);
    t_d = (err || tmo || we) ? t_a + 1 : t_a + RD_LAT + 1;
    if (err) t_d = n + 1;
    t_addr = addr >> 2;
    t_we   = we ? (((32'd1 << nb) - 1) << addr[1:0]) : 32'd0;
    t_wd   = (nb == 1) ? {4{wdata[7:0]}} : (nb == 2) ? {2{wdata[15:0]}} : wdata;
    v = 0;
    if (!err && !tmo && !we) begin
      for (int k = 0; k < nb; k++) v = v | (32'(rb(int'(addr) + k)) << (8*k));
      if (nb < 4 && !uns && v[8*nb-1]) begin
        m = 32'hFFFF_FFFF << (8*nb);
        v = v | m;
      end
    end
    if (!err && !tmo && we)
      for (int k = 0; k < nb; k++) ref_b[int'(addr) + k] = wdata[8*k +: 8];
    t_rdata = v; t_mis = err; t_tmo = tmo;
    ready_from = n + 1 + stall;
    req = 1'b1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    d0 = done_seen;
    pulse = (extra && t_d >= n + 2) ? n + 1 + $urandom_range(0, t_d - n - 1) : -1;
    while (cyc <= t_d) begin
      @(posedge clk); #1;
      req = (cyc == pulse);
      req_we = 1'($urandom()); req_size = 2'($urandom()); req_unsigned = 1'($urandom());
      req_addr = $urandom(); req_wdata = $urandom();
      if (rst_mid && cyc == t_a + 1) begin
        reset = 1'b1;
        t_n = -10; t_a = -10; t_d = -10;
        #1;
        check("rst_busy", busy, 0);       check("rst_done", done, 0);
        check("rst_ram_en", ram_en, 0);   check("rst_ram_we", ram_we, 0);
        check("rst_rdata", rdata, 0);     check("rst_ram_addr", {2'b00, ram_addr}, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
    end
    req = 1'b0;
    check("done_count", done_seen - d0, rst_mid ? 0 : 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st;
    reset = 1'b0; req = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    #2 reset = 1'b1;
    #1;
    check("reset_busy", busy, 0);   check("reset_done", done, 0);
    check("reset_ram_en", ram_en, 0); check("reset_ram_we", ram_we, 0);
    check("reset_rdata", rdata, 0); check("reset_misaligned", misaligned, 0);
    check("reset_timeout", timeout, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // word load at 0x100
    poke_word(32'h40, 32'hDEADBEEF);
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);
    check("pin_wl_rdata", rdata, 32'hDEADBEEF);
    check("pin_wl_addr", last_acc_addr, 32'h40);
    check("pin_wl_we", last_acc_we, 4'b0000);
    check("pin_wl_lat", last_done_cyc - last_acc_cyc, 3);

    // byte loads at 0x103
    poke_word(32'h40, 32'h80112233);
    do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 1'b0, 1'b0);
    check("pin_lb_signed", rdata, 32'hFFFFFF80);
    do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 1'b0, 1'b0);
    check("pin_lb_unsigned", rdata, 32'h00000080);

    // half store at 0x102
    do_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 0, 1'b0, 1'b0);
    check("pin_sh_we", last_acc_we, 4'b1100);
    check("pin_sh_wdata", last_acc_wd, 32'hABCDABCD);
    check("pin_sh_lat", last_done_cyc - last_acc_cyc, 1);
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);
    check("pin_sh_readback", rdata, 32'hABCD2233);

    // 5-cycle stall with a stray req mid-transaction
    do_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5, 1'b1, 1'b0);
    check("pin_stall_acc", last_acc_cyc - t_n, 6);
    check("pin_stall_rdata", rdata, 32'hFFFFABCD);

    // alignment errors
    do_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 1'b0, 1'b0);
    check("pin_err_wl_mis", misaligned, 1);
    check("pin_err_wl_rdata", rdata, 0);
    check("pin_err_wl_lat", last_done_cyc - t_n, 1);
    do_txn(1'b1, 2'd1, 1'b0, 32'h203, 32'h5555, 0, 1'b1, 1'b0);
    check("pin_err_sh_mis", misaligned, 1);
    do_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);
    check("pin_err_rsv_mis", misaligned, 1);

    // reset during WAIT, then a normal word load at 0x0
    poke_word(0, 32'hCAFE0001);
    do_txn(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0, 1'b0, 1'b1);
    do_txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    check("pin_post_rst_rdata", rdata, 32'hCAFE0001);

`ifdef MEM_TIMEOUT_EN
    do_txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 50, 1'b0, 1'b0);
    check("pin_tmo_flag", timeout, 1);
    check("pin_tmo_rdata", rdata, 0);
    check("pin_tmo_lat", last_done_cyc - t_n, TMO_CYC + 1);
`else
    do_txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 20, 1'b0, 1'b0);
    check("pin_long_stall_acc", last_acc_cyc - t_n, 21);
    check("pin_long_stall_tmo", timeout, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      st = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 2);
      do_txn(1'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom()),
             32'h100 + $urandom_range(0, 31), $urandom(), st, 1'($urandom()), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got cyc %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
